multdiv: RTL and testbench
==========================

MULTDIV -- requirements
Module: multdiv

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL provide port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL provide port data_operandA  input  WIDTH  signed two's-complement multiplicand / dividend.
REQ-005 SHALL provide port data_operandB  input  WIDTH  signed two's-complement multiplier / divisor.
REQ-006 SHALL provide port ctrl_MULT  input  1  single-cycle start-multiply pulse.
REQ-007 SHALL provide port ctrl_DIV  input  1  single-cycle start-divide pulse.
REQ-008 SHALL provide port data_result  output  WIDTH  product low WIDTH bits or quotient; feeds the writeback result-select mux.
REQ-009 SHALL provide port data_exception  output  1  overflow or divide-by-zero flag, valid with data_resultRDY.
REQ-010 SHALL provide port data_resultRDY  output  1  one-cycle result-valid strobe.

Function
REQ-011 SHALL implement states IDLE, MULT, DIV, DONE in a registered state machine.
REQ-012 SHALL, on an edge sampling ctrl_MULT=1 (edge 0), capture both operands, clear the iteration counter, clear data_result and data_exception, and enter MULT.
REQ-013 SHALL, on an edge sampling ctrl_DIV=1 and ctrl_MULT=0, do the same and enter DIV.
REQ-014 SHALL give ctrl_MULT priority when ctrl_MULT and ctrl_DIV are sampled high on the same edge.
REQ-015 SHALL accept a start pulse in any state; a start during MULT, DIV or DONE aborts the current operation and restarts from edge 0 with the newly captured operands, with no data_resultRDY emitted for the aborted operation.
REQ-016 SHALL ignore operand input changes after edge 0; only the captured values are used.
REQ-017 SHALL perform one iteration per edge on edges 1..WIDTH: radix-2 Booth step for MULT, restoring shift-subtract step on operand magnitudes for DIV.
REQ-018 SHALL, on edge WIDTH+1, load data_result and data_exception, enter DONE, and drive data_resultRDY=1 for exactly one cycle (edge WIDTH+1 to edge WIDTH+2).
REQ-019 SHALL return from DONE to IDLE on edge WIDTH+2 unless a start is sampled on that edge.
REQ-020 SHALL hold data_result and data_exception stable from edge WIDTH+1 until the next accepted start.
REQ-021 SHALL produce, for MULT, data_result = low WIDTH bits of the exact 2*WIDTH-bit signed product.
REQ-022 SHALL assert data_exception for MULT iff the exact product is outside the signed WIDTH-bit range (upper WIDTH+1 product bits not all equal).
REQ-023 SHALL produce, for DIV, the signed quotient truncated toward zero, with quotient sign = sign(A) XOR sign(B); the remainder is discarded.
REQ-024 SHALL, for DIV with B=0, output data_result=0 and data_exception=1 at the normal latency.
REQ-025 SHALL, for DIV with A=most-negative and B=-1, output data_result=most-negative (0x80000000 at WIDTH=32) and data_exception=1.
REQ-026 SHALL keep data_exception=0 for every other DIV case.
REQ-027 SHALL keep data_resultRDY=0 in IDLE, MULT and DIV.

Reset
REQ-028 SHALL, while reset=1 and independent of clock, force state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, and clear all internal operand registers.
REQ-029 SHALL abort any operation in progress when reset asserts; no data_resultRDY follows for it.
REQ-030 SHALL ignore ctrl_MULT and ctrl_DIV on any edge where reset=1, and SHALL accept a start on the first edge after reset deasserts.

Verification
REQ-031 SHALL pass: MULT A=7, B=-6 -> data_resultRDY high only in cycle WIDTH+1..WIDTH+2 (33..34), result 0xFFFFFFD6, exception 0.
REQ-032 SHALL pass: MULT A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1; MULT A=0x80000000, B=1 -> result 0x80000000, exception 0.
REQ-033 SHALL pass: DIV A=-17, B=5 -> result 0xFFFFFFFD (-3), exception 0; DIV A=100, B=0 -> result 0, exception 1.
REQ-034 SHALL pass: DIV A=0x80000000, B=-1 -> result 0x80000000, exception 1.
REQ-035 SHALL pass: MULT 3*4 started, then DIV 20/4 pulsed on edge 10 -> single RDY strobe 33 edges after edge 10, result 5; both ctrl pulses on one edge with A=2, B=3 -> result 6.
REQ-036 SHALL pass: reset asserted mid-MULT at edge 15 asynchronously between edges -> outputs 0 immediately, no RDY strobe for that operation; new MULT 2*2 after release -> result 4.

Source files
------------

// File: rtl/multdiv.sv
// ---------------------------------------------------------------------------
// multdiv -- iterative signed multiplier / divider
//
// Multiply uses a radix-2 Booth recoder and divide uses a restoring
// shift-subtract on operand magnitudes. Each operation takes one iteration
// per clock edge, for WIDTH edges in total. The result and exception are
// loaded one edge after the last iteration, and a one-cycle ready strobe
// accompanies them.
//
// Handshake: a start is a single-cycle pulse on ctrl_MULT or ctrl_DIV. It is
// accepted on any edge where reset is low, in any state. ctrl_MULT wins if
// both are high. Accepting a start aborts any operation in progress.
// data_resultRDY is high for exactly one cycle per completed operation, and
// data_result/data_exception are valid with it. Both then hold until the
// next accepted start.
//
// Ports
//   clock          : sole clock, rising edge
//   reset          : asynchronous, active-high
//   data_operandA  : signed multiplicand / dividend (captured at start)
//   data_operandB  : signed multiplier / divisor   (captured at start)
//   ctrl_MULT      : start-multiply pulse
//   ctrl_DIV       : start-divide pulse
//   data_result    : low WIDTH product bits, or quotient
//   data_exception : multiply overflow, divide-by-zero, or MIN/-1 overflow
//   data_resultRDY : one-cycle result-valid strobe
//   o_dbg_state    : current FSM state (IDLE=0, MULT=1, DIV=2, DONE=3)
// ---------------------------------------------------------------------------
module multdiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic [1:0]       o_dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_exc;

    // Booth accumulator layout: {upper (WIDTH+1), multiplier (WIDTH), q-1}.
    // The upper half carries one extra bit so that subtracting the most
    // negative multiplicand cannot overflow.
    logic [2*WIDTH+1:0] r_prod;
    logic [WIDTH:0]     r_mcand;

    // Divider: partial remainder, quotient (starts as |A|), divisor |B|.
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvsr;
    logic               r_neg;

    logic               w_start;
    logic               w_last;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_booth_upper;
    logic [WIDTH:0]     w_booth_sum;
    logic [2*WIDTH+1:0] w_prod_next;
    logic [WIDTH:0]     w_mult_hi;
    logic               w_mult_ovf;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_fits;
    logic [WIDTH-1:0]   w_quo_signed;

    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_last  = (r_cnt == CW'(WIDTH));

    // Magnitudes as unsigned values; the most negative operand maps to
    // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
    assign w_abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign w_abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // ---------------- Booth step ----------------
    assign w_booth_upper = r_prod[2*WIDTH+1:WIDTH+1];

    always_comb begin
        w_booth_sum = w_booth_upper;
        case (r_prod[1:0])
            2'b01:   w_booth_sum = w_booth_upper + r_mcand;
            2'b10:   w_booth_sum = w_booth_upper - r_mcand;
            default: w_booth_sum = w_booth_upper;
        endcase
    end

    // Arithmetic shift right by one of {sum, multiplier, q-1}.
    assign w_prod_next = {w_booth_sum[WIDTH], w_booth_sum, r_prod[WIDTH:1]};

    // The 2*WIDTH-bit product sits in r_prod[2*WIDTH:1]. It fits in WIDTH
    // signed bits only if its top WIDTH+1 bits are all equal.
    assign w_mult_hi  = r_prod[2*WIDTH:WIDTH];
    assign w_mult_ovf = ~((&w_mult_hi) | ~(|w_mult_hi));

    // ---------------- Restoring divide step ----------------
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvsr};
    assign w_fits   = ~w_diff[WIDTH];

    assign w_quo_signed = r_neg ? -r_quo : r_quo;

    // ---------------- FSM ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        data_resultRDY = 1'b0;
        if (ctrl_MULT) begin
            w_next_state = MULT;
        end else if (ctrl_DIV) begin
            w_next_state = DIV;
        end else begin
            case (r_state)
                IDLE:    w_next_state = IDLE;
                MULT:    w_next_state = w_last ? DONE : MULT;
                DIV:     w_next_state = w_last ? DONE : DIV;
                DONE:    w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
        if (r_state == DONE) begin
            data_resultRDY = 1'b1;
        end
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
            r_neg    <= 1'b0;
        end else if (w_start) begin
            r_cnt    <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_prod   <= {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
            r_mcand  <= {data_operandA[WIDTH-1], data_operandA};
            r_rem    <= '0;
            r_quo    <= w_abs_a;
            r_dvsr   <= w_abs_b;
            r_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        end else begin
            case (r_state)
                MULT: begin
                    if (!w_last) begin
                        r_prod <= w_prod_next;
                        r_cnt  <= r_cnt + CW'(1);
                    end else begin
                        r_result <= r_prod[WIDTH:1];
                        r_exc    <= w_mult_ovf;
                    end
                end
                DIV: begin
                    if (!w_last) begin
                        r_rem  <= w_fits ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
                        r_quo  <= {r_quo[WIDTH-2:0], w_fits};
                        r_cnt  <= r_cnt + CW'(1);
                    end else if (r_dvsr == '0) begin
                        r_result <= '0;
                        r_exc    <= 1'b1;
                    end else begin
                        // A positive quotient with its top bit set can only
                        // come from MIN / -1; it wraps to MIN and flags.
                        r_result <= w_quo_signed;
                        r_exc    <= ~r_neg & r_quo[WIDTH-1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_multdiv.sv
// ---------------------------------------------------------------------------
// tb_multdiv -- scoreboard bench for multdiv (WIDTH=32)
// Starts push {result, exception, ready edge} into expected queues; a
// monitor on the falling edge pops and compares on every ready strobe.
// ---------------------------------------------------------------------------
module tb_multdiv;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] data_operandA = '0;
    logic [W-1:0] data_operandB = '0;
    logic         ctrl_MULT = 1'b0;
    logic         ctrl_DIV = 1'b0;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic [1:0]   o_dbg_state;

    multdiv #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .o_dbg_state    (o_dbg_state)
    );

    // ---------------- clock / reset / edge counter ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic         exp_exc_q[$];
    int           exp_edge_q[$];
    int           n_cmp = 0;
    int           n_fail = 0;
    logic [W-1:0] last_r = '0;
    logic         last_e = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain signed arithmetic on 64-bit integers.
    function automatic void model(input bit is_mult, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic e);
        longint p;
        longint lo;
        longint hi;
        int     sa;
        int     sb;
        sa = a;
        sb = b;
        hi = (longint'(1) << (W - 1)) - 1;
        lo = -(longint'(1) << (W - 1));
        if (is_mult) begin
            p = longint'(sa) * longint'(sb);
            r = p[W-1:0];
            e = (p > hi) || (p < lo);
        end else if (sb == 0) begin
            r = '0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            r = sa / sb;
            e = 1'b0;
        end
    endfunction

    function automatic void flush_expected();
        exp_q.delete();
        exp_exc_q.delete();
        exp_edge_q.delete();
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (!reset && data_resultRDY) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rdy: got strobe at edge %0d, required none", cyc);
            end else begin
                logic [W-1:0] r;
                logic         e;
                int           ed;
                r  = exp_q.pop_front();
                e  = exp_exc_q.pop_front();
                ed = exp_edge_q.pop_front();
                check("result", data_result, r);
                check("exception", W'(data_exception), W'(e));
                check("rdy_edge", W'(cyc), W'(ed));
                last_r = r;
                last_e = e;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Wait until at least edge n has happened, then step just past it.
    task automatic wait_edge(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Called just after an edge: the start is sampled on the next edge.
    // A new start discards any operation still outstanding.
    task automatic issue(input bit do_mult, input bit do_div, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         e;
        model(do_mult, a, b, r, e);
        flush_expected();
        exp_q.push_back(r);
        exp_exc_q.push_back(e);
        exp_edge_q.push_back(cyc + 1 + W + 1);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = do_mult;
        ctrl_DIV      = do_div;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clock);
            #1;
            t++;
        end
        check("drain_timeout", W'(exp_q.size()), '0);
        flush_expected();
    endtask

    task automatic check_hold();
        repeat (3) @(posedge clock);
        #1;
        check("hold_result", data_result, last_r);
        check("hold_exception", W'(data_exception), W'(last_e));
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = $urandom;
            1:       v = '0;
            2:       v = 32'h0000_0001;
            3:       v = 32'hFFFF_FFFF;
            4:       v = 32'h8000_0000;
            default: v = W'($urandom_range(0, 40)) - 32'd20;
        endcase
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int s;
        int sel;
        #2;
        check("reset_result", data_result, '0);
        check("reset_exception", W'(data_exception), '0);
        check("reset_rdy", W'(data_resultRDY), '0);

        // A start pulsed while reset is high must be ignored.
        wait_edge(2);
        data_operandA = 32'd5;
        data_operandB = 32'd5;
        ctrl_MULT     = 1'b1;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        reset     = 1'b0;
        wait_edge(cyc + 40);

        // Directed corner cases.
        issue(1, 0, 32'd7, -32'sd6);               wait_idle(); check_hold();
        issue(1, 0, 32'h0001_0000, 32'h0001_0000); wait_idle();
        issue(1, 0, 32'h8000_0000, 32'd1);         wait_idle();
        issue(0, 1, -32'sd17, 32'd5);              wait_idle();
        issue(0, 1, 32'd100, 32'd0);               wait_idle();
        issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle(); check_hold();

        // Restart: DIV pulsed on edge 10 of a MULT.
        s = cyc + 1;
        issue(1, 0, 32'd3, 32'd4);
        wait_edge(s + 9);
        issue(0, 1, 32'd20, 32'd4);
        wait_idle();

        // Both pulses on one edge: multiply wins.
        issue(1, 1, 32'd2, 32'd3); wait_idle();

        // Async reset between edges clears held outputs at once.
        issue(1, 0, 32'd9, 32'd9); wait_idle();
        #3;
        reset = 1'b1;
        #1;
        check("async_clear_result", data_result, '0);
        check("async_clear_exception", W'(data_exception), '0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset mid-MULT at edge 15: no strobe for the aborted operation,
        // and a start on the first edge after release is accepted.
        s = cyc + 1;
        issue(1, 0, 32'd5, 32'd9);
        wait_edge(s + 15);
        #3;
        reset = 1'b1;
        flush_expected();
        #1;
        check("midop_reset_result", data_result, '0);
        check("midop_reset_rdy", W'(data_resultRDY), '0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        issue(1, 0, 32'd2, 32'd2);
        wait_idle();

        // Randomized operations with occasional restarts mid-flight.
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 4);
            issue(sel == 0 || sel == 2 || sel == 3, sel == 1 || sel == 4 || sel == 2,
                  pick_operand(), pick_operand());
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 36)) @(posedge clock);
                #1;
            end else begin
                wait_idle();
                repeat ($urandom_range(0, 2)) @(posedge clock);
                #1;
            end
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
